key_extract_param: RTL and testbench
====================================

KEY_EXTRACT_PARAM -- requirements
Module: key_extract_param

Interface
REQ-001 Parameter PHV_LEN, default 1124, PHV width: 8x6B, 8x4B and 8x2B containers, MSB-first, then 5x20b comparator ops at [355:256], then metadata [255:0].
REQ-002 Parameter NK6 / NK4 / NK2, default 2 / 2 / 2, number of 6B / 4B / 2B key fields, each 1..8.
REQ-003 Parameter NCMP, default 5, number of comparator slots evaluated, 1..5.
REQ-004 Parameter ADDR_W, default 4, tenant table address width; DEPTH = 2^ADDR_W.
REQ-005 Parameter TID_LSB, default 133, LSB of the tenant index field phv_in[TID_LSB+ADDR_W-1:TID_LSB], which is vlan_id[7:4].
REQ-006 Derived: OFF_W = 3*(NK6+NK4+NK2)+NCMP, which SHALL be at most 32; KEY_LEN = 48*NK6+32*NK4+16*NK2+NCMP.
REQ-007 clk  in  1  clock; rst_n  in  1  asynchronous, active-low reset.
REQ-008 phv_in  in  PHV_LEN  PHV; phv_valid_in  in  1  PHV valid; phv_ready_out  out  1  upstream accept.
REQ-009 phv_out  out  PHV_LEN  delayed PHV; key_out  out  KEY_LEN  extracted key; out_valid  out  1  phv_out/key_out valid; out_ready  in  1  downstream accept.
REQ-010 cfg_wr_en  in  1; cfg_wr_addr  in  ADDR_W; cfg_wr_data  in  32 (only [OFF_W-1:0] used); cfg_rd_addr  in  ADDR_W; cfg_rd_data  out  32  registered readback, zero-extended.

Function
REQ-011 Handshake: a PHV is accepted on cycles where phv_valid_in && phv_ready_out; an output transfers on cycles where out_valid && out_ready.
REQ-012 Two-stage pipeline: a PHV accepted in cycle T presents out_valid in cycle T+2 when there is no stall.
- Stage 1 registers the containers, the comparator ops, the PHV and the table entry read.
- Stage 2 registers key_out.
REQ-013 phv_ready_out = !(S1 valid && S2 valid && !out_ready). With out_ready held high, the block sustains 1 PHV per cycle.
REQ-014 While out_valid && !out_ready, phv_out and key_out SHALL hold stable, and no PHV is lost or duplicated.
REQ-015 Table entry layout, MSB-first:
- NK6 3-bit indices, then NK4, then NK2;
- then an NCMP-bit cmp_mask, where bit NCMP-1 corresponds to slot 0.
REQ-016 Key layout, MSB-first: 6B fields, then 4B fields, then 2B fields (field j = container[index j]), then NCMP compare bits with slot 0 at the MSB.
REQ-017 Comparator slot k uses op bits phv[355-20k -: 20]:
- [19:18] 00 gt, 01 ge, 10 eq, 11 constant 1;
- operand A: if [17] is set, imm [16:9]; else container type [13:12] (10=6B, 01=4B, 00=2B, 11 -> operand 0), index [11:9], low byte;
- operand B: same encoding using [8], [7:0], [4:3] and [2:0];
- comparisons are unsigned 8-bit.
REQ-018 Compare bit k is forced to 1 when the cmp_mask bit for slot k is 0.
REQ-019 The table entry is selected by the tenant index of the PHV at its acceptance.
- A cfg write in cycle W affects PHVs accepted at W+1 or later.
- A same-cycle write to the same address does not affect the PHV accepted in that cycle.
REQ-020 A stalled PHV keeps the entry it captured at acceptance; later writes do not alter it.
REQ-021 cfg_rd_data returns entry[cfg_rd_addr] one cycle after the address is presented; a same-cycle write to that address returns the old value.
REQ-022 cfg_wr_addr covers the full table; there is no out-of-range condition.

Reset
REQ-023 While rst_n is low, SHALL force immediately: out_valid=0, key_out=0, phv_out=0, cfg_rd_data=0, all table entries=0, internal valid flags=0.
REQ-024 phv_ready_out SHALL be 1 during and after reset.
REQ-025 A reset asserted mid-stream SHALL discard in-flight PHVs; none are emitted after release.
REQ-026 A table of all-zero entries yields every key field = container[0] and all compare bits = 1.

Verification
REQ-027 Write entry 3 = indices {6B:7,0; 4B:1,2; 2B:3,4}, mask 11111. Send a PHV with vlan_id[7:4]=3 -> key fields equal containers 6B[7], 6B[0], 4B[1], 4B[2], 2B[3], 2B[4]; out_valid at T+2.
REQ-028 Slot 0 op = ge, imm A=0x10, imm B=0x10 -> compare bit 0 = 1. Change to gt -> 0. Cmp_mask bit cleared -> 1 regardless.
REQ-029 Hold out_ready=0 and stream 4 PHVs -> exactly 2 accepted, phv_ready_out=0, outputs stable. Release -> 4 PHVs out in order, no gaps or duplicates.
REQ-030 Write entry 5 in the same cycle a PHV with tenant 5 is accepted -> that PHV uses the old entry; the next PHV uses the new entry. cfg_rd_data shows old then new.
REQ-031 Assert rst_n low with 2 PHVs in flight -> out_valid=0 immediately; no output after release. cfg_rd_data from any address = 0.
REQ-032 Back-to-back stream of 100 PHVs with random tenants and out_ready=1 -> 100 outputs, 1 per cycle, matching a reference model.

Source files
------------

// File: rtl/key_extract_param_if.sv
// Stream and tenant-table configuration signals of the key extractor.
// The slave modport is the extractor's view; the master modport drives it.
interface key_extract_param_if #(
  parameter int PHV_LEN = 1124,
  parameter int KEY_LEN = 197,
  parameter int ADDR_W  = 4
);
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid_in;
  logic               phv_ready_out;
  logic [PHV_LEN-1:0] phv_out;
  logic [KEY_LEN-1:0] key_out;
  logic               out_valid;
  logic               out_ready;
  logic               cfg_wr_en;
  logic [ADDR_W-1:0]  cfg_wr_addr;
  logic [31:0]        cfg_wr_data;
  logic [ADDR_W-1:0]  cfg_rd_addr;
  logic [31:0]        cfg_rd_data;

  modport master (
    output phv_in, phv_valid_in, out_ready, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
    input  phv_ready_out, phv_out, key_out, out_valid, cfg_rd_data
  );

  modport slave (
    input  phv_in, phv_valid_in, out_ready, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
    output phv_ready_out, phv_out, key_out, out_valid, cfg_rd_data
  );
endinterface

// File: rtl/key_extract_param.sv
// Two-stage key extractor: selects PHV containers and evaluates comparator slots
// according to a per-tenant offset table, emitting the PHV alongside its key.
module key_extract_param #(
  parameter int PHV_LEN = 1124,
  parameter int NK6     = 2,
  parameter int NK4     = 2,
  parameter int NK2     = 2,
  parameter int NCMP    = 5,
  parameter int ADDR_W  = 4,
  parameter int TID_LSB = 133
) (
  input  logic clk,
  input  logic rst_n,
  key_extract_param_if.slave bus
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NF      = NK6 + NK4 + NK2;
  localparam int OFF_W   = 3 * NF + NCMP;
  localparam int KEY_LEN = 48 * NK6 + 32 * NK4 + 16 * NK2 + NCMP;
  localparam int C6_TOP  = PHV_LEN - 1;
  localparam int C4_TOP  = PHV_LEN - 1 - 8 * 48;
  localparam int C2_TOP  = PHV_LEN - 1 - 8 * 48 - 8 * 32;
  localparam int OPS_TOP = 355;

  // Low byte of a container; type 11 is a constant-zero operand.
  function automatic logic [7:0] byte_of(input logic [PHV_LEN-1:0] p,
                                         input logic [1:0] typ,
                                         input logic [2:0] idx);
    logic [7:0] b;
    case (typ)
      2'b10:   b = p[C6_TOP - 48 * int'(idx) - 40 -: 8];
      2'b01:   b = p[C4_TOP - 32 * int'(idx) - 24 -: 8];
      2'b00:   b = p[C2_TOP - 16 * int'(idx) - 8 -: 8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic cmp_bit(input logic [PHV_LEN-1:0] p, input logic [19:0] op);
    logic [7:0] a;
    logic [7:0] b;
    logic       r;
    a = op[17] ? op[16:9] : byte_of(p, op[13:12], op[11:9]);
    b = op[8]  ? op[7:0]  : byte_of(p, op[4:3], op[2:0]);
    case (op[19:18])
      2'b00:   r = (a > b);
      2'b01:   r = (a >= b);
      2'b10:   r = (a == b);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [OFF_W-1:0]   table_r [DEPTH];
  logic [31:0]        cfg_rd_data_r;
  logic               s1_valid_r;
  logic [PHV_LEN-1:0] s1_phv_r;
  logic [OFF_W-1:0]   s1_entry_r;
  logic               s2_valid_r;
  logic [PHV_LEN-1:0] s2_phv_r;
  logic [KEY_LEN-1:0] s2_key_r;
  logic [KEY_LEN-1:0] key_s;
  logic [2:0]         ix_s;
  logic [ADDR_W-1:0]  tid_s;
  logic               ready_s;
  logic               accept_s;
  logic               s2_load_s;

  assign tid_s     = bus.phv_in[TID_LSB + ADDR_W - 1 : TID_LSB];
  assign ready_s   = !(s1_valid_r && s2_valid_r && !bus.out_ready);
  assign accept_s  = bus.phv_valid_in && ready_s;
  assign s2_load_s = s1_valid_r && (!s2_valid_r || bus.out_ready);

  assign bus.phv_ready_out = ready_s;
  assign bus.out_valid     = s2_valid_r;
  assign bus.phv_out       = s2_phv_r;
  assign bus.key_out       = s2_key_r;
  assign bus.cfg_rd_data   = cfg_rd_data_r;

  generate
    if (OFF_W < 32) begin : g_cfg_hi
      logic unused_cfg_hi_s;
      assign unused_cfg_hi_s = ^bus.cfg_wr_data[31:OFF_W];
    end
  endgenerate

  // Tenant table writes and registered readback (read sees pre-write contents)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_r[i] <= '0;
      cfg_rd_data_r <= 32'h0000_0000;
    end else begin
      if (bus.cfg_wr_en) table_r[bus.cfg_wr_addr] <= bus.cfg_wr_data[OFF_W-1:0];
      cfg_rd_data_r <= 32'(table_r[bus.cfg_rd_addr]);
    end
  end

  // Stage 1: capture the PHV with the entry its tenant had at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_phv_r   <= '0;
      s1_entry_r <= '0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_phv_r   <= bus.phv_in;
      s1_entry_r <= table_r[tid_s];
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Key assembly from the stage-1 PHV and its captured entry
  always_comb begin
    key_s = '0;
    ix_s  = 3'd0;
    for (int j = 0; j < NK6; j++) begin
      ix_s = s1_entry_r[OFF_W - 1 - 3 * j -: 3];
      key_s[KEY_LEN - 1 - 48 * j -: 48] = s1_phv_r[C6_TOP - 48 * int'(ix_s) -: 48];
    end
    for (int j = 0; j < NK4; j++) begin
      ix_s = s1_entry_r[OFF_W - 1 - 3 * (NK6 + j) -: 3];
      key_s[KEY_LEN - 1 - 48 * NK6 - 32 * j -: 32] = s1_phv_r[C4_TOP - 32 * int'(ix_s) -: 32];
    end
    for (int j = 0; j < NK2; j++) begin
      ix_s = s1_entry_r[OFF_W - 1 - 3 * (NK6 + NK4 + j) -: 3];
      key_s[KEY_LEN - 1 - 48 * NK6 - 32 * NK4 - 16 * j -: 16] =
        s1_phv_r[C2_TOP - 16 * int'(ix_s) -: 16];
    end
    for (int k = 0; k < NCMP; k++) begin
      key_s[NCMP - 1 - k] = !s1_entry_r[NCMP - 1 - k] |
                            cmp_bit(s1_phv_r, s1_phv_r[OPS_TOP - 20 * k -: 20]);
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_phv_r   <= '0;
      s2_key_r   <= '0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_phv_r   <= s1_phv_r;
      s2_key_r   <= key_s;
    end else if (bus.out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_extract_param.sv
// Randomised bench for key_extract_param against an arithmetic reference model
// of the tenant table, key layout and comparator rules.
module tb_key_extract_param;
  localparam int PHV_LEN = 1124;
  localparam int NK6 = 2, NK4 = 2, NK2 = 2, NCMP = 5;
  localparam int ADDR_W = 4, TID_LSB = 133;
  localparam int NF = NK6 + NK4 + NK2;
  localparam int OFF_W = 3 * NF + NCMP;
  localparam int KEY_LEN = 48 * NK6 + 32 * NK4 + 16 * NK2 + NCMP;

  typedef struct {
    logic [KEY_LEN-1:0] key;
    logic [PHV_LEN-1:0] phv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  exp_t exp_q[$];
  logic [OFF_W-1:0] tbl_m [16];
  logic stall_prev = 1'b0;
  logic [KEY_LEN-1:0] held_m;
  logic [255:0]       held_p_m;

  key_extract_param_if #(.PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ADDR_W(ADDR_W)) bus ();

  key_extract_param #(
    .PHV_LEN(PHV_LEN), .NK6(NK6), .NK4(NK4), .NK2(NK2), .NCMP(NCMP),
    .ADDR_W(ADDR_W), .TID_LSB(TID_LSB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] chunk(input logic [PHV_LEN-1:0] p, input int i);
    return 256'(p >> (256 * i));
  endfunction

  function automatic logic [7:0] m_byte(input logic [PHV_LEN-1:0] p, input int typ, input int ix);
    int lsb;
    if (typ == 2) lsb = PHV_LEN - 48 * (ix + 1);
    else if (typ == 1) lsb = PHV_LEN - 384 - 32 * (ix + 1);
    else if (typ == 0) lsb = PHV_LEN - 640 - 16 * (ix + 1);
    else return 8'h00;
    return 8'(p >> lsb);
  endfunction

  function automatic logic [KEY_LEN-1:0] model_key(input logic [PHV_LEN-1:0] p,
                                                  input logic [OFF_W-1:0] e);
    logic [KEY_LEN-1:0] k;
    logic [19:0] op;
    int ix, a, b, fn;
    bit r;
    k = '0;
    for (int f = 0; f < NF; f++) begin
      ix = int'((e >> (OFF_W - 3 * (f + 1))) & 7);
      if (f < NK6)
        k = (k << 48) | KEY_LEN'(48'(p >> (PHV_LEN - 48 * (ix + 1))));
      else if (f < NK6 + NK4)
        k = (k << 32) | KEY_LEN'(32'(p >> (PHV_LEN - 384 - 32 * (ix + 1))));
      else
        k = (k << 16) | KEY_LEN'(16'(p >> (PHV_LEN - 640 - 16 * (ix + 1))));
    end
    for (int s = 0; s < NCMP; s++) begin
      op = 20'(p >> (336 - 20 * s));
      fn = int'(op >> 18);
      a = op[17] ? int'(op[16:9]) : int'(m_byte(p, int'(op[13:12]), int'(op[11:9])));
      b = op[8]  ? int'(op[7:0])  : int'(m_byte(p, int'(op[4:3]), int'(op[2:0])));
      if (((e >> (NCMP - 1 - s)) & 1) == 0) r = 1'b1;
      else if (fn == 0) r = (a > b);
      else if (fn == 1) r = (a >= b);
      else if (fn == 2) r = (a == b);
      else r = 1'b1;
      k = (k << 1) | KEY_LEN'(r);
    end
    return k;
  endfunction

  function automatic logic [PHV_LEN-1:0] rand_phv(input int tid);
    logic [PHV_LEN-1:0] p;
    p = '0;
    for (int i = 0; i < 36; i++) p = (p << 32) | PHV_LEN'($urandom());
    p[TID_LSB +: 4] = 4'(tid);
    return p;
  endfunction

  // Scoreboard: outputs checked in order, acceptances predicted with the pre-write table
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.out_valid) begin
        check_val("stall_key_stable", bus.key_out, held_m);
        check_val("stall_phv_stable", chunk(bus.phv_out, 0), held_p_m);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_m = bus.key_out;
      held_p_m = chunk(bus.phv_out, 0);
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 256'd1, 256'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("key_out", bus.key_out, e.key);
          for (int c = 0; c < 5; c++) check_val("phv_out", chunk(bus.phv_out, c), chunk(e.phv, c));
        end
      end
      if (bus.phv_valid_in && bus.phv_ready_out) begin
        exp_t n;
        n.phv = bus.phv_in;
        n.key = model_key(bus.phv_in, tbl_m[int'(bus.phv_in[TID_LSB +: 4])]);
        exp_q.push_back(n);
      end
      if (bus.cfg_wr_en) tbl_m[bus.cfg_wr_addr] = bus.cfg_wr_data[OFF_W-1:0];
    end
  end

  task automatic send(input logic [PHV_LEN-1:0] p);
    int g;
    g = 0;
    bus.phv_in = p;
    bus.phv_valid_in = 1'b1;
    @(negedge clk);
    while (!bus.phv_ready_out && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.phv_ready_out) check_val("send_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
    bus.phv_valid_in = 1'b0;
  endtask

  task automatic send_get(input logic [PHV_LEN-1:0] p, output logic [KEY_LEN-1:0] k);
    int g;
    g = 0;
    send(p);
    @(negedge clk);
    while (!bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.out_valid) check_val("out_timeout", 256'd0, 256'd1);
    k = bus.key_out;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    bus.cfg_wr_en = 1'b1;
    bus.cfg_wr_addr = 4'(a);
    bus.cfg_wr_data = d;
    @(posedge clk);
    #1;
    bus.cfg_wr_en = 1'b0;
  endtask

  logic [PHV_LEN-1:0] p, pq[4];
  logic [KEY_LEN-1:0] k, held;
  logic [OFF_W-1:0]   e_old, e_new;
  int o0, c0, idx, nacc, n, guard;
  bit acc;

  initial begin
    for (int i = 0; i < 16; i++) tbl_m[i] = '0;
    rst_n = 1'b0;
    bus.phv_in = '0;
    bus.phv_valid_in = 1'b0;
    bus.out_ready = 1'b1;
    bus.cfg_wr_en = 1'b0;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = 32'h0;
    bus.cfg_rd_addr = '0;
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 256'd0);
    check_val("rst_key_out", bus.key_out, 256'd0);
    check_val("rst_phv_out", chunk(bus.phv_out, 4), 256'd0);
    check_val("rst_ready", bus.phv_ready_out, 256'd1);
    check_val("rst_rd_data", bus.cfg_rd_data, 256'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All-zero table: every field is container 0, compare bits all ones
    p = rand_phv(2);
    send_get(p, k);
    check_val("zero_tbl_key", k,
              {p[1123 -: 48], p[1123 -: 48], p[739 -: 32], p[739 -: 32], p[483 -: 16], p[483 -: 16], 5'b11111});

    // Entry 3 field selection and two-cycle latency
    cfg_write(3, 32'({3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 5'b11111}));
    p = rand_phv(3);
    send(p);
    @(negedge clk);
    check_val("lat_t1_valid", bus.out_valid, 256'd0);
    @(negedge clk);
    check_val("lat_t2_valid", bus.out_valid, 256'd1);
    check_val("entry3_fields", bus.key_out[KEY_LEN-1:NCMP],
              {p[1123 - 48*7 -: 48], p[1123 -: 48], p[739 - 32 -: 32], p[739 - 64 -: 32],
               p[483 - 48 -: 16], p[483 - 64 -: 16]});
    @(posedge clk);
    #1;

    // Comparator slot 0: ge / gt on equal immediates, then masked
    cfg_write(1, 32'h1F);
    p = rand_phv(1);
    p[355 -: 20] = {2'b01, 1'b1, 8'h10, 1'b1, 8'h10};
    send_get(p, k);
    check_val("cmp_ge_eq", k[NCMP-1], 256'd1);
    p[355 -: 20] = {2'b00, 1'b1, 8'h10, 1'b1, 8'h10};
    send_get(p, k);
    check_val("cmp_gt_eq", k[NCMP-1], 256'd0);
    cfg_write(1, 32'h0F);
    send_get(p, k);
    check_val("cmp_masked", k[NCMP-1], 256'd1);

    // Stall with four queued PHVs: two taken, outputs held, then drained in order
    for (int i = 0; i < 4; i++) pq[i] = rand_phv(i);
    bus.out_ready = 1'b0;
    idx = 0;
    nacc = 0;
    bus.phv_in = pq[0];
    bus.phv_valid_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = bus.phv_valid_in && bus.phv_ready_out;
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        idx++;
        if (idx < 4) bus.phv_in = pq[idx];
        else bus.phv_valid_in = 1'b0;
      end
    end
    @(negedge clk);
    check_val("stall_accepted", 256'(nacc), 256'd2);
    check_val("stall_ready", bus.phv_ready_out, 256'd0);
    check_val("stall_valid", bus.out_valid, 256'd1);
    held = bus.key_out;
    @(negedge clk);
    check_val("stall_hold", bus.key_out, held);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("drain_valid", bus.out_valid, 256'd1);
      acc = bus.phv_valid_in && bus.phv_ready_out;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) bus.phv_in = pq[idx];
        else bus.phv_valid_in = 1'b0;
      end
    end
    @(negedge clk);
    check_val("drain_done", bus.out_valid, 256'd0);
    @(posedge clk);
    #1;

    // Same-cycle write to entry 5 does not affect the PHV accepted with it
    e_old = {18'd0, 5'h1F};
    e_new = {3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 5'h1F};
    cfg_write(5, 32'(e_old));
    bus.cfg_rd_addr = 4'd5;
    @(posedge clk);
    #1;
    bus.cfg_wr_en = 1'b1;
    bus.cfg_wr_addr = 4'd5;
    bus.cfg_wr_data = 32'(e_new);
    bus.phv_in = rand_phv(5);
    bus.phv_valid_in = 1'b1;
    @(negedge clk);
    check_val("rd_before_wr", bus.cfg_rd_data, 256'(e_old));
    @(posedge clk);
    #1;
    bus.cfg_wr_en = 1'b0;
    bus.phv_in = rand_phv(5);
    @(negedge clk);
    check_val("rd_same_cycle", bus.cfg_rd_data, 256'(e_old));
    @(posedge clk);
    #1;
    bus.phv_valid_in = 1'b0;
    @(negedge clk);
    check_val("rd_after_wr", bus.cfg_rd_data, 256'(e_new));
    repeat (3) @(posedge clk);
    #1;

    // Random table contents and readback
    for (int a = 0; a < 16; a++) cfg_write(a, $urandom());
    for (int a = 0; a < 16; a += 5) begin
      bus.cfg_rd_addr = 4'(a);
      @(posedge clk);
      #1;
      check_val("rd_random", bus.cfg_rd_data, 256'(tbl_m[a]));
    end

    // Back-to-back stream with random tenants
    o0 = out_cnt;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(rand_phv(int'($urandom_range(0, 15))));
    check_val("b2b_cycles", 256'(cyc - c0), 256'd100);
    @(posedge clk);
    #1;
    check_val("b2b_out_m1", 256'(out_cnt - o0), 256'd99);
    @(posedge clk);
    #1;
    check_val("b2b_out", 256'(out_cnt - o0), 256'd100);

    // Random backpressure
    n = 0;
    guard = 0;
    while (n < 60 && guard < 2000) begin
      bus.out_ready = ($urandom() % 4) != 0;
      if (!bus.phv_valid_in && ($urandom() % 3) != 0) begin
        bus.phv_in = rand_phv(int'($urandom_range(0, 15)));
        bus.phv_valid_in = 1'b1;
      end
      @(negedge clk);
      acc = bus.phv_valid_in && bus.phv_ready_out;
      @(posedge clk);
      #1;
      if (acc) begin
        n++;
        bus.phv_valid_in = 1'b0;
      end
      guard++;
    end
    check_val("rand_accepted", 256'(n), 256'd60);
    bus.phv_valid_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("rand_drained", 256'(exp_q.size()), 256'd0);

    // Reset with two PHVs in flight
    bus.out_ready = 1'b0;
    send(rand_phv(3));
    send(rand_phv(4));
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", bus.out_valid, 256'd0);
    check_val("midrst_key", bus.key_out, 256'd0);
    check_val("midrst_rd", bus.cfg_rd_data, 256'd0);
    check_val("midrst_ready", bus.phv_ready_out, 256'd1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) tbl_m[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.cfg_rd_addr = 4'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("postrst_no_out", bus.out_valid, 256'd0);
    end
    check_val("postrst_rd", bus.cfg_rd_data, 256'd0);
    @(posedge clk);
    #1;
    check_val("final_queue", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
